gpu_tile_engine: RTL and testbench
==================================

Name: gpu_tile_engine

Overview:
- Per-pixel scene generator between the VGA timing block and the sprite colour stage.
- For each (h_pos, v_pos) from the VGA timing block, outputs:
  - a sprite index, consumed by the sprite controller;
  - a background RGB colour.
- Also contains a one-second timebase that animates a single sprite across a tile grid.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency. Benches shrink it to speed up simulation.
- H_ACTIVE, 640: visible pixels per line.
- V_ACTIVE, 480: visible lines per frame.
- TILE_LOG2, 5: log2 of the tile edge in pixels, giving 32x32 tiles.
- SPRITE_ID, 8'h01: base index of the animated sprite.
- BG0_RGB, 24'h202040: colour of even-parity tiles.
- BG1_RGB, 24'h404080: colour of odd-parity tiles.

Ports:
- clk  in  1  pixel/system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- h_pos  in  10  current horizontal pixel coordinate.
- v_pos  in  10  current vertical pixel coordinate.
- indice  out  8  sprite index for the current pixel; 0 means background only.
- R_out  out  8  background red.
- G_out  out  8  background green.
- B_out  out  8  background blue.
- clock_segundo  out  1  1 Hz square wave.
- contador_segundo  out  26  timebase counter value.

Behaviour:
- Reset (asynchronous, active-high):
  - indice, R_out, G_out, B_out, contador_segundo, clock_segundo = 0.
  - Sprite tile position (sx, sy) = (0, 0); animation frame = 0.
- Timebase:
  - contador_segundo counts 0 .. CLK_HZ/2-1, then wraps to 0.
  - On the wrap cycle, clock_segundo toggles.
  - Period is therefore CLK_HZ cycles (1 Hz at 50 MHz).
- Second tick:
  - Defined as the wrap cycle on which clock_segundo goes 0->1 (once per CLK_HZ cycles).
  - On each tick: frame toggles and sx increments.
  - When sx = H_ACTIVE>>TILE_LOG2 - 1 (19), sx wraps to 0 and sy increments.
  - When sy = V_ACTIVE>>TILE_LOG2 - 1 (14) and it would increment, sy wraps to 0.
- Pixel path, one registered stage (outputs valid 1 clock after h_pos/v_pos are presented):
  - tx = h_pos>>TILE_LOG2, ty = v_pos>>TILE_LOG2.
  - If h_pos >= H_ACTIVE or v_pos >= V_ACTIVE: indice = 0, RGB = 0.
  - Else, if (tx, ty) == (sx, sy): indice = SPRITE_ID + frame. RGB still carries the background colour for that tile.
  - Else: indice = 0.
  - Background colour = BG1_RGB if tx[0]^ty[0] = 1, else BG0_RGB; R = [23:16], G = [15:8], B = [7:0].
- Simultaneous events:
  - If a tick and a pixel of the old sprite tile occur in the same cycle, that pixel uses the pre-tick (sx, sy, frame).
  - The new position is visible from the next cycle.
- Reset mid-frame: all state returns to reset values immediately; counting resumes from 0 on the first edge after rst falls.
- No handshake; the block is purely streaming.

Optional Feature:
- Macro GPU_BORDER_EN.
- When defined: pixels with h_pos < 2, h_pos >= H_ACTIVE-2, v_pos < 2 or v_pos >= V_ACTIVE-2 (inside the active area) output RGB = 24'hFFFFFF and indice = 0. The border overrides both the sprite and the background.
- When undefined: no border; edge pixels follow the normal tile rules.

Decomposition:
- Package gpu_pkg holds:
  - H_ACTIVE, V_ACTIVE and TILE_LOG2 defaults;
  - the tile-count constants (20, 15);
  - the 24-bit RGB typedef and the BG colour defaults.
- One natural sub-module: gpu_second_timer. It contains contador_segundo, clock_segundo and the tick pulse; the remainder is the tile/colour pipeline.

Test Plan:
- Reset: assert rst at t=0 and release after 17 time units. All outputs are 0 during reset; contador_segundo = 1 after the first post-reset edge.
- Background:
  - h_pos=0, v_pos=0 gives indice=8'h01 one clock later (sprite at (0,0), frame 0), R/G/B = 20/20/40.
  - h_pos=32, v_pos=0 gives indice=0, R/G/B = 40/40/80.
  - h_pos=64, v_pos=32 gives R/G/B = 40/40/80.
- Blanking: h_pos=640, v_pos=100 gives indice=0, RGB=0. Repeat for h_pos=10, v_pos=480.
- Timebase (CLK_HZ=8):
  - contador_segundo sequences 0,1,2,3,0.
  - clock_segundo toggles every 4 cycles.
  - After 8 cycles the sprite is at (1,0): pixel (32,0) gives indice=8'h02; pixel (0,0) gives indice=0.
- Wrap (CLK_HZ=8): after 20 ticks, sprite at (0,1), so pixel (5,40) gives indice=SPRITE_ID+(20 mod 2)=8'h01. After 300 ticks, sprite back at (0,0).
- With GPU_BORDER_EN: pixel (1,200) gives RGB=FFFFFF, indice=0. Pixel (0,0) gives RGB=FFFFFF, indice=0 even while the sprite sits at (0,0).

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants and types for the tile engine: default screen geometry,
// tile-grid dimensions and the default background colours.
package gpu_pkg;

   typedef logic [23:0] rgb_t;

   localparam int H_ACTIVE_DEF  = 640;
   localparam int V_ACTIVE_DEF  = 480;
   localparam int TILE_LOG2_DEF = 5;

   localparam int TILES_X = H_ACTIVE_DEF >> TILE_LOG2_DEF;   // 20
   localparam int TILES_Y = V_ACTIVE_DEF >> TILE_LOG2_DEF;   // 15

   localparam rgb_t BG0_RGB_DEF    = 24'h202040;
   localparam rgb_t BG1_RGB_DEF    = 24'h404080;
   localparam rgb_t BORDER_RGB     = 24'hFFFFFF;

endpackage

// File: rtl/gpu_second_timer.sv
// One-second timebase: half-period counter, 1 Hz square wave and a single
// cycle tick on the wrap where the square wave rises.
module gpu_second_timer
   import gpu_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [25:0] o_count,
   output logic        o_clk_1hz,
   output logic        o_tick
);

   localparam logic [25:0] HALF_M1 = 26'(CLK_HZ / 2 - 1);

   logic [25:0] r_count;
   logic        r_clk_1hz;
   logic        w_wrap;

   assign w_wrap    = (r_count == HALF_M1);
   assign o_tick    = w_wrap && !r_clk_1hz;
   assign o_count   = r_count;
   assign o_clk_1hz = r_clk_1hz;

   // Half-period counter; square wave flips on every wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count   <= '0;
         r_clk_1hz <= 1'b0;
      end else if (w_wrap) begin
         r_count   <= '0;
         r_clk_1hz <= ~r_clk_1hz;
      end else begin
         r_count   <= r_count + 26'd1;
      end
   end

endmodule

// File: rtl/gpu_tile_engine.sv
// Per-pixel scene generator: checkerboard tile background plus one animated
// sprite that steps across the tile grid once per second.
// Optional build macro GPU_BORDER_EN paints a 2-pixel white frame around the
// active area, overriding sprite and background.
module gpu_tile_engine
   import gpu_pkg::*;
#(
   parameter int         CLK_HZ    = 50_000_000,
   parameter int         H_ACTIVE  = H_ACTIVE_DEF,
   parameter int         V_ACTIVE  = V_ACTIVE_DEF,
   parameter int         TILE_LOG2 = TILE_LOG2_DEF,
   parameter logic [7:0] SPRITE_ID = 8'h01,
   parameter rgb_t       BG0_RGB   = BG0_RGB_DEF,
   parameter rgb_t       BG1_RGB   = BG1_RGB_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  h_pos,
   input  logic [9:0]  v_pos,
   output logic [7:0]  indice,
   output logic [7:0]  R_out,
   output logic [7:0]  G_out,
   output logic [7:0]  B_out,
   output logic        clock_segundo,
   output logic [25:0] contador_segundo
);

   localparam logic [9:0] H_LIM   = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM   = 10'(V_ACTIVE);
   localparam logic [9:0] TX_LAST = 10'((H_ACTIVE >> TILE_LOG2) - 1);
   localparam logic [9:0] TY_LAST = 10'((V_ACTIVE >> TILE_LOG2) - 1);

   logic       w_tick;
   logic [9:0] w_tx;
   logic [9:0] w_ty;
   logic       w_active;
   logic [7:0] w_idx_d;
   rgb_t       w_rgb_d;

   logic [9:0] r_sx;
   logic [9:0] r_sy;
   logic       r_frame;
   logic [7:0] r_idx;
   rgb_t       r_rgb;

   gpu_second_timer #(
      .CLK_HZ (CLK_HZ)
   ) u_timer (
      .i_clk     (clk),
      .i_rst     (rst),
      .o_count   (contador_segundo),
      .o_clk_1hz (clock_segundo),
      .o_tick    (w_tick)
   );

   assign w_tx     = h_pos >> TILE_LOG2;
   assign w_ty     = v_pos >> TILE_LOG2;
   assign w_active = (h_pos < H_LIM) && (v_pos < V_LIM);

   // Sprite walks the grid row-major, one tile per tick, alternating frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sx    <= '0;
         r_sy    <= '0;
         r_frame <= 1'b0;
      end else if (w_tick) begin
         r_frame <= ~r_frame;
         if (r_sx == TX_LAST) begin
            r_sx <= '0;
            r_sy <= (r_sy == TY_LAST) ? '0 : r_sy + 10'd1;
         end else begin
            r_sx <= r_sx + 10'd1;
         end
      end
   end

   // Pixel decision; uses the sprite state held before any same-cycle tick.
   always_comb begin
      w_idx_d = '0;
      w_rgb_d = '0;
      if (w_active) begin
         w_rgb_d = (w_tx[0] ^ w_ty[0]) ? BG1_RGB : BG0_RGB;
         if ((w_tx == r_sx) && (w_ty == r_sy))
            w_idx_d = SPRITE_ID + {7'd0, r_frame};
`ifdef GPU_BORDER_EN
         if ((h_pos < 10'd2) || (h_pos >= H_LIM - 10'd2) ||
             (v_pos < 10'd2) || (v_pos >= V_LIM - 10'd2)) begin
            w_idx_d = '0;
            w_rgb_d = BORDER_RGB;
         end
`endif
      end
   end

   // Single output register stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_rgb <= '0;
      end else begin
         r_idx <= w_idx_d;
         r_rgb <= w_rgb_d;
      end
   end

   assign indice = r_idx;
   assign R_out  = r_rgb[23:16];
   assign G_out  = r_rgb[15:8];
   assign B_out  = r_rgb[7:0];

endmodule

// File: tb/tb_gpu_tile_engine.sv
// Bench for gpu_tile_engine with a shrunk clock rate (CLK_HZ = 8).
// Honours GPU_BORDER_EN when the build defines it.
module tb_gpu_tile_engine;

   localparam int CLK_HZ = 8;
   localparam int HALF   = CLK_HZ / 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  h_pos = '0;
   logic [9:0]  v_pos = '0;
   logic [7:0]  indice;
   logic [7:0]  R_out, G_out, B_out;
   logic        clock_segundo;
   logic [25:0] contador_segundo;

   int n_checks = 0;
   int n_errors = 0;
   int n_edge   = 0;

   gpu_tile_engine #(.CLK_HZ(CLK_HZ)) dut (
      .clk              (clk),
      .rst              (rst),
      .h_pos            (h_pos),
      .v_pos            (v_pos),
      .indice           (indice),
      .R_out            (R_out),
      .G_out            (G_out),
      .B_out            (B_out),
      .clock_segundo    (clock_segundo),
      .contador_segundo (contador_segundo)
   );

   always #5 clk = ~clk;

   // Edges elapsed since reset released.
   always @(posedge clk or posedge rst) begin
      if (rst) n_edge <= 0;
      else     n_edge <= n_edge + 1;
   end

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", nm, act, exp, $time, n_edge);
      end
   endtask

   // Ticks that have happened after n edges: first at edge HALF, then every CLK_HZ.
   function automatic int ticks_at(input int n);
      if (n < HALF) return 0;
      return (n - HALF) / CLK_HZ + 1;
   endfunction

   function automatic void sprite_after(input int n, output int sx, output int sy, output int fr);
      int t;
      t  = ticks_at(n);
      sx = t % 20;
      sy = (t / 20) % 15;
      fr = t % 2;
   endfunction

   task automatic model_check(input string nm, input int h, input int v);
      int sx, sy, fr, tx, ty;
      logic [7:0]  e_idx;
      logic [23:0] e_rgb;
      sprite_after(n_edge - 1, sx, sy, fr);
      e_idx = 8'h00;
      e_rgb = 24'h0;
      if (h < 640 && v < 480) begin
         tx = h / 32;
         ty = v / 32;
         e_rgb = ((tx + ty) % 2 == 1) ? 24'h404080 : 24'h202040;
         if (tx == sx && ty == sy) e_idx = 8'(1 + fr);
`ifdef GPU_BORDER_EN
         if (h < 2 || h >= 638 || v < 2 || v >= 478) begin
            e_idx = 8'h00;
            e_rgb = 24'hFFFFFF;
         end
`endif
      end
      cmp({nm, " indice"}, 32'(indice), 32'(e_idx));
      cmp({nm, " rgb"}, 32'({R_out, G_out, B_out}), 32'(e_rgb));
      cmp({nm, " contador"}, 32'(contador_segundo), 32'(n_edge % HALF));
      cmp({nm, " clock_segundo"}, 32'(clock_segundo), 32'((n_edge / HALF) % 2));
   endtask

   // Present a pixel, wait for the edge that registers it, settle.
   task automatic px(input int h, input int v);
      h_pos = 10'(h);
      v_pos = 10'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      int          h;
      int          v;
      logic [7:0]  idx;
      logic [23:0] rgb;
   } vec_t;

   vec_t tbl[8];

   int cnt_exp[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
   int clk_exp[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
   int idx_exp[8] = '{1, 1, 1, 1, 0, 2, 0, 0};

   initial begin
`ifdef GPU_BORDER_EN
      tbl[0] = '{0,   0,   8'h00, 24'hFFFFFF};
      tbl[1] = '{32,  0,   8'h00, 24'hFFFFFF};
      tbl[2] = '{639, 479, 8'h00, 24'hFFFFFF};
      tbl[3] = '{1,   200, 8'h00, 24'hFFFFFF};
`else
      tbl[0] = '{0,   0,   8'h01, 24'h202040};
      tbl[1] = '{32,  0,   8'h00, 24'h404080};
      tbl[2] = '{639, 479, 8'h00, 24'h404080};
      tbl[3] = '{1,   200, 8'h00, 24'h202040};
`endif
      tbl[4] = '{64,  32,  8'h00, 24'h404080};
      tbl[5] = '{640, 100, 8'h00, 24'h000000};
      tbl[6] = '{10,  480, 8'h00, 24'h000000};
      tbl[7] = '{33,  33,  8'h00, 24'h202040};

      // Reset state
      #10;
      cmp("reset indice", 32'(indice), 32'h0);
      cmp("reset rgb", 32'({R_out, G_out, B_out}), 32'h0);
      cmp("reset contador", 32'(contador_segundo), 32'h0);
      cmp("reset clock_segundo", 32'(clock_segundo), 32'h0);
      #7 rst = 1'b0;

      // Timebase and first step; edge 4 is a tick landing on the old sprite tile
      for (int i = 0; i < 8; i++) begin
         if (i == 5) px(33, 2);
         else        px(2, 2);
         cmp($sformatf("tb contador e%0d", i + 1), 32'(contador_segundo), 32'(cnt_exp[i]));
         cmp($sformatf("tb clock_segundo e%0d", i + 1), 32'(clock_segundo), 32'(clk_exp[i]));
         cmp($sformatf("tb indice e%0d", i + 1), 32'(indice), 32'(idx_exp[i]));
      end

      // Fixed vectors, each from a fresh reset (sprite at (0,0), frame 0)
      for (int i = 0; i < 8; i++) begin
         do_reset();
         px(tbl[i].h, tbl[i].v);
         cmp($sformatf("vec%0d indice", i), 32'(indice), 32'(tbl[i].idx));
         cmp($sformatf("vec%0d rgb", i), 32'({R_out, G_out, B_out}), 32'(tbl[i].rgb));
      end

      // Row wrap after 20 ticks, grid wrap after 300 ticks
      do_reset();
      idle(156);
      px(5, 40);
      cmp("wrap20 indice", 32'(indice), 32'h01);
      model_check("wrap20", 5, 40);
      px(0, 40);
      model_check("wrap20b", 0, 40);
      idle(2237);
      px(620, 470);
      cmp("tick299 indice", 32'(indice), 32'h02);
      px(2, 2);
      cmp("wrap300 indice", 32'(indice), 32'h01);
      px(33, 2);
      cmp("wrap300 neighbour", 32'(indice), 32'h00);

      // Random stimulus against the model, with an asynchronous reset midway
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int h, v, sx, sy, fr;
         if (i == 300) begin
            #3 rst = 1'b1;
            #1;
            cmp("async rst indice", 32'(indice), 32'h0);
            cmp("async rst contador", 32'(contador_segundo), 32'h0);
            cmp("async rst clock", 32'(clock_segundo), 32'h0);
            @(posedge clk);
            #1 rst = 1'b0;
         end
         if ($urandom_range(3) == 0) begin
            sprite_after(n_edge, sx, sy, fr);
            h = sx * 32 + int'($urandom_range(31));
            v = sy * 32 + int'($urandom_range(31));
         end else begin
            h = int'($urandom_range(700));
            v = int'($urandom_range(520));
         end
         px(h, v);
         model_check("rand", h, v);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
